cpu_execute_stage_mc: RTL

// Parametrised execute stage with an integrated EX/MEM pipeline register. It performs operand forwarding, a

---
 rtl/cpu_execute_stage_mc.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_execute_stage_mc.sv
// Execute stage with EX/MEM register, forwarding, ALU,
// iterative shift-add multiplier and registered NZVC flags.
module cpu_execute_stage_mc #(
  parameter int WIDTH        = 16,
  parameter int ADDRESSWIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    validE,
  input  logic [2:0]              aluControlE,
  input  logic                    data2SelectorE,
  input  logic [1:0]              data1ForwardSelectorE,
  input  logic [1:0]              data2ForwardSelectorE,
  input  logic [WIDTH-1:0]        reg1ContentE,
  input  logic [WIDTH-1:0]        reg2ContentE,
  input  logic [WIDTH-1:0]        inmmediateE,
  input  logic [WIDTH-1:0]        forwardM,
  input  logic [WIDTH-1:0]        forwardWB,
  input  logic [ADDRESSWIDTH-1:0] regDestinationAddressE,
  input  logic                    PCSelectorFE,
  input  logic                    writeEnableDE,
  input  logic                    writeDataEnableME,
  input  logic                    resultSelectorWBE,
  input  logic                    setFlagsE,
  input  logic                    flushE,
  input  logic                    stallM,
  output logic                    busyE,
  output logic [WIDTH-1:0]        aluOutputM,
  output logic [WIDTH-1:0]        reg2ContentM,
  output logic [ADDRESSWIDTH-1:0] regDestinationAddressM,
  output logic                    PCSelectorFM,
  output logic                    writeEnableDM,
  output logic                    writeDataEnableMM,
  output logic                    resultSelectorWBM,
  output logic                    validM,
  output logic                    N,
  output logic                    Z,
  output logic                    V,
  output logic                    C
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam int M = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_q, alu_d, st_q, st_d;
  logic [ADDRESSWIDTH-1:0] dst_q, dst_d;
  logic [3:0] ctl_q, ctl_d;
  logic valid_q, valid_d;
  logic [3:0] flags_q, flags_d;

  logic [WIDTH-1:0] op_a, fwd_b, op_b, bop, res;
  logic [WIDTH:0]   sum;
  logic sub, res_c, res_v;
  logic mul_start, busy, done, load, bubble;

  // Operand forwarding and operand B select
  always_comb begin
    case (data1ForwardSelectorE)
      2'b01:   op_a = forwardWB;
      2'b10:   op_a = forwardM;
      default: op_a = reg1ContentE;
    endcase
    case (data2ForwardSelectorE)
      2'b01:   fwd_b = forwardWB;
      2'b10:   fwd_b = forwardM;
      default: fwd_b = reg2ContentE;
    endcase
    op_b = data2SelectorE ? inmmediateE : fwd_b;
  end

  // Single-cycle ALU, or finished product while in DONE
  always_comb begin
    sub   = (aluControlE == 3'b001);
    bop   = sub ? ~op_b : op_b;
    sum   = {1'b0, op_a} + {1'b0, bop} + {{WIDTH{1'b0}}, sub};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    if (state_q == DONE) begin
      res   = acc_q[WIDTH-1:0];
      res_c = |acc_q[2*WIDTH-1:WIDTH];
    end else begin
      case (aluControlE)
        3'b000, 3'b001: begin
          res   = sum[WIDTH-1:0];
          res_c = sum[WIDTH];
          res_v = (op_a[M] == bop[M]) && (sum[M] != op_a[M]);
        end
        3'b010:  res = op_a & op_b;
        3'b011:  res = op_a | op_b;
        3'b100:  res = op_a ^ op_b;
        3'b101:  res = op_a;
        3'b110:  res = op_b;
        default: res = '0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mul_start) state_d = RUN;
      RUN: begin
        if (flushE)               state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: if (flushE || !stallM) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and EX/MEM load decision
  always_comb begin
    mul_start = (state_q == IDLE) && validE && !flushE
              && (aluControlE == 3'b111);
    busy   = mul_start || (state_q == RUN);
    done   = (state_q == DONE);
    load   = !stallM && validE && !flushE && !busy;
    bubble = !stallM && !load;
  end

  assign busyE = busy;

  // Multiplier datapath: latch at start, one shift-add per RUN cycle
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (mul_start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, op_a};
      mplier_d = op_b;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  // EX/MEM register and flag next values
  always_comb begin
    alu_d   = alu_q;
    st_d    = st_q;
    dst_d   = dst_q;
    ctl_d   = ctl_q;
    valid_d = valid_q;
    flags_d = flags_q;
    if (bubble) begin
      alu_d   = '0;
      st_d    = '0;
      dst_d   = '0;
      ctl_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      alu_d   = res;
      st_d    = fwd_b;
      dst_d   = regDestinationAddressE;
      ctl_d   = {PCSelectorFE, writeEnableDE,
                 writeDataEnableME, resultSelectorWBE};
      valid_d = 1'b1;
      if (setFlagsE)
        flags_d = {res[M], (res == '0), res_v, res_c};
    end
  end

  // Datapath and pipeline register state
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      alu_q    <= '0;
      st_q     <= '0;
      dst_q    <= '0;
      ctl_q    <= '0;
      valid_q  <= 1'b0;
      flags_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      alu_q    <= alu_d;
      st_q     <= st_d;
      dst_q    <= dst_d;
      ctl_q    <= ctl_d;
      valid_q  <= valid_d;
      flags_q  <= flags_d;
    end
  end

  assign aluOutputM             = alu_q;
  assign reg2ContentM           = st_q;
  assign regDestinationAddressM = dst_q;
  assign {PCSelectorFM, writeEnableDM,
          writeDataEnableMM, resultSelectorWBM} = ctl_q;
  assign validM = valid_q;
  assign {N, Z, V, C} = flags_q;

  logic unused;
  assign unused = done;

endmodule
